// File: rtl/intersection_pkg.sv
// Shared types and default phase durations for the intersection controller.
package intersection_pkg;

    // Phase sequence; the encoding is also exposed on the debug phase port.
    typedef enum logic [2:0] {
        StNsGreen  = 3'd0,
        StNsYellow = 3'd1,
        StAllRed1  = 3'd2,
        StEwGreen  = 3'd3,
        StEwYellow = 3'd4,
        StAllRed2  = 3'd5
    } state_t;

    localparam int unsigned DefCntW     = 8;
    localparam int unsigned DefGreenMin = 20;
    localparam int unsigned DefYellowT  = 4;
    localparam int unsigned DefAllredT  = 2;
    localparam int unsigned DefEwGreenT = 10;

endpackage

// File: rtl/phase_timer.sv
// Shared phase timer: clears on phase change, counts up, optionally holds at term.
module phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             sat,
    input  logic [CNT_W-1:0] term,
    output logic             done
);

    logic [CNT_W-1:0] count_q, count_d;

    assign done = (count_q == term);

    // Next count: clear wins, saturation holds at term, otherwise increment.
    always_comb begin
        count_d = count_q + 1'b1;
        if (clr) begin
            count_d = '0;
        end else if (sat && done) begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/intersection_ctrl.sv
// Two-road intersection controller: NS main road, demand-driven EW side road.
module intersection_ctrl
    import intersection_pkg::*;
#(
    parameter int unsigned CNT_W      = DefCntW,
    parameter int unsigned GREEN_MIN  = DefGreenMin,
    parameter int unsigned YELLOW_T   = DefYellowT,
    parameter int unsigned ALLRED_T   = DefAllredT,
    parameter int unsigned EW_GREEN_T = DefEwGreenT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ew_req,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       ew_walk,
    output logic       ew_pending,
    output logic [2:0] phase
);

    // Timer terminal values are duration - 1: a phase of D cycles exits when count == D-1.
    localparam logic [CNT_W-1:0] GreenMinTerm = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] YellowTerm   = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AllredTerm   = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] EwGreenTerm  = CNT_W'(EW_GREEN_T - 1);

    state_t           state_q, state_d;
    logic             pending_q, pending_d;
    logic             tmr_clr, tmr_sat, tmr_done;
    logic [CNT_W-1:0] tmr_term;

    // Select the timer terminal count for the current phase.
    always_comb begin
        tmr_term = AllredTerm;
        unique case (state_q)
            StNsGreen:  tmr_term = GreenMinTerm;
            StNsYellow: tmr_term = YellowTerm;
            StAllRed1:  tmr_term = AllredTerm;
            StEwGreen:  tmr_term = EwGreenTerm;
            StEwYellow: tmr_term = YellowTerm;
            StAllRed2:  tmr_term = AllredTerm;
            default:    tmr_term = AllredTerm;
        endcase
    end

    // NS green holds at min-green so a late request is served on the next edge.
    assign tmr_sat = (state_q == StNsGreen);
    assign tmr_clr = (state_d != state_q);

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmr_clr),
        .sat  (tmr_sat),
        .term (tmr_term),
        .done (tmr_done)
    );

    // Next phase and pending request; entering EW green consumes the request.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        unique case (state_q)
            StNsGreen:  if (tmr_done && pending_q) state_d = StNsYellow;
            StNsYellow: if (tmr_done) state_d = StAllRed1;
            StAllRed1:  if (tmr_done) state_d = StEwGreen;
            StEwGreen:  if (tmr_done) state_d = StEwYellow;
            StEwYellow: if (tmr_done) state_d = StAllRed2;
            StAllRed2:  if (tmr_done) state_d = StNsGreen;
            default:    state_d = StAllRed2;
        endcase
        if (ew_req && (state_q != StEwGreen)) begin
            pending_d = 1'b1;
        end
        if ((state_d == StEwGreen) && (state_q != StEwGreen)) begin
            pending_d = 1'b0;
        end
    end

    // Phase and pending registers; reset lands in all-red clearance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StAllRed2;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    // Moore lamp decode; anything unrecognised shows all-red.
    always_comb begin
        ns_red    = 1'b1;
        ns_yellow = 1'b0;
        ns_green  = 1'b0;
        ew_red    = 1'b1;
        ew_yellow = 1'b0;
        ew_green  = 1'b0;
        ew_walk   = 1'b0;
        unique case (state_q)
            StNsGreen: begin
                ns_red   = 1'b0;
                ns_green = 1'b1;
            end
            StNsYellow: begin
                ns_red    = 1'b0;
                ns_yellow = 1'b1;
            end
            StEwGreen: begin
                ew_red   = 1'b0;
                ew_green = 1'b1;
                ew_walk  = 1'b1;
            end
            StEwYellow: begin
                ew_red    = 1'b0;
                ew_yellow = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign ew_pending = pending_q;
    assign phase      = state_q;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Randomized and directed bench for intersection_ctrl against a phase-level model.
module tb_intersection_ctrl;
    import intersection_pkg::*;

    localparam int GMIN = 4;
    localparam int YT   = 2;
    localparam int ART  = 1;
    localparam int EWT  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ew_req = 1'b0;
    logic       ns_red, ns_yellow, ns_green;
    logic       ew_red, ew_yellow, ew_green;
    logic       ew_walk, ew_pending;
    logic [2:0] phase;

    always #5 clk = ~clk;

    intersection_ctrl #(
        .CNT_W      (8),
        .GREEN_MIN  (GMIN),
        .YELLOW_T   (YT),
        .ALLRED_T   (ART),
        .EW_GREEN_T (EWT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ew_req     (ew_req),
        .ns_red     (ns_red),
        .ns_yellow  (ns_yellow),
        .ns_green   (ns_green),
        .ew_red     (ew_red),
        .ew_yellow  (ew_yellow),
        .ew_green   (ew_green),
        .ew_walk    (ew_walk),
        .ew_pending (ew_pending),
        .phase      (phase)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: phase index in sequence order, cycles spent in phase, pending flag.
    int     m_ph;
    int     m_el;
    bit     m_pend;
    int     dur    [6];
    state_t ph_map [6];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ew_walk}
    function automatic logic [6:0] exp_lamps(input int ph);
        case (ph)
            0:       return 7'b001_100_0;
            1:       return 7'b010_100_0;
            3:       return 7'b100_001_1;
            4:       return 7'b100_010_0;
            default: return 7'b100_100_0;
        endcase
    endfunction

    task automatic model_reset();
        m_ph   = 5;
        m_el   = 0;
        m_pend = 0;
    endtask

    task automatic model_step();
        bit leave;
        if (m_ph == 0) leave = (m_el >= GMIN - 1) && m_pend;
        else           leave = (m_el == dur[m_ph] - 1);
        if (ew_req && m_ph != 3) m_pend = 1;
        if (leave) begin
            m_ph = (m_ph + 1) % 6;
            m_el = 0;
            if (m_ph == 3) m_pend = 0;
        end else begin
            m_el++;
        end
    endtask

    task automatic compare_all();
        check_eq("lamps", {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ew_walk},
                 exp_lamps(m_ph));
        check_eq("phase", phase, ph_map[m_ph]);
        check_eq("pending", ew_pending, m_pend);
        check_eq("safety", (ns_green | ns_yellow) & (ew_green | ew_yellow), 0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #1;
        compare_all();
    endtask

    // Asynchronous assert away from the clock edge, hold n edges, then release.
    task automatic do_reset(input int n);
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic wait_phase(input int p, input int bound);
        for (int i = 0; i < bound && m_ph != p; i++) tick();
        check_eq("reach_phase", phase, ph_map[p]);
    endtask

    task automatic pulse_req();
        ew_req = 1'b1;
        tick();
        ew_req = 1'b0;
    endtask

    initial begin
        dur    = '{GMIN, YT, ART, EWT, YT, ART};
        ph_map = '{StNsGreen, StNsYellow, StAllRed1, StEwGreen, StEwYellow, StAllRed2};
        model_reset();
        #2;

        // Reset held 3 cycles, then one all-red cycle before NS green.
        do_reset(3);
        tick();
        check_eq("post_reset_ns_green", ns_green, 1);

        // Idle: NS green holds.
        repeat (100) tick();
        check_eq("idle_hold", phase, StNsGreen);

        // Early request in the first NS green cycle.
        do_reset(1);
        tick();
        pulse_req();
        repeat (20) tick();

        // Late request: pending next cycle, yellow the cycle after.
        repeat (10) tick();
        pulse_req();
        check_eq("late_pend", ew_pending, 1);
        tick();
        check_eq("late_yellow", phase, StNsYellow);

        // Request during EW green is ignored.
        wait_phase(3, 20);
        pulse_req();
        wait_phase(0, 20);
        repeat (20) tick();
        check_eq("ignored_hold", ns_green, 1);

        // Request during EW yellow triggers a second service.
        pulse_req();
        wait_phase(4, 30);
        pulse_req();
        check_eq("yellow_req_pend", ew_pending, 1);
        wait_phase(0, 20);
        repeat (20) tick();

        // Reset in the middle of EW green.
        pulse_req();
        wait_phase(3, 30);
        tick();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check_eq("midrst_pend", ew_pending, 0);
        check_eq("midrst_allred", {ns_red, ew_red}, 2'b11);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check_eq("midrst_ns_green", phase, StNsGreen);

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            ew_req = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 299) == 0) begin
                ew_req = 1'b0;
                do_reset($urandom_range(1, 3));
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
